// File: rtl/reverse_dabble_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package reverse_dabble_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [3:0] DABBLE_THRESHOLD  = 4'd8;
  localparam logic [3:0] DABBLE_CORRECTION = 4'd3;

  function automatic logic nibble_invalid(input logic [3:0] nibble);
    return nibble > 4'd9;
  endfunction

endpackage

// File: rtl/dabble_sub3.sv
// Single-nibble reverse-dabble adjust: digits that reach 8 after a right shift lose 3.
module dabble_sub3
  import reverse_dabble_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= DABBLE_THRESHOLD) ? digit - DABBLE_CORRECTION : digit;

endmodule

// File: rtl/reverse_dabble.sv
// Sequential BCD-to-binary converter: one shift-and-correct step per clock,
// flags invalid digits and results wider than OUTPUT_BITS.
module reverse_dabble
  import reverse_dabble_pkg::*;
#(
  parameter  int INPUT_DIGITS = 5,
  localparam int INPUT_BITS   = INPUT_DIGITS * 4,
  parameter  int OUTPUT_BITS  = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start_i,
  input  logic [INPUT_BITS-1:0]  BCD_i,
  output logic                   Busy_o,
  output logic                   Done_o,
  output logic [OUTPUT_BITS-1:0] Binary_o,
  output logic                   Error_o
);

  localparam int CNT_BITS = $clog2(OUTPUT_BITS + 1);
  localparam logic [CNT_BITS-1:0] LAST_ITER = CNT_BITS'(OUTPUT_BITS - 1);

  state_t                  state;
  logic [INPUT_BITS-1:0]   bcd_reg;
  logic [INPUT_BITS-1:0]   bcd_shifted;
  logic [INPUT_BITS-1:0]   bcd_next;
  logic [OUTPUT_BITS-1:0]  bin_reg;
  logic [CNT_BITS-1:0]     count;
  logic                    digit_err;
  logic                    bcd_invalid;

  always_comb begin
    bcd_invalid = 1'b0;
    for (int unsigned i = 0; i < INPUT_DIGITS; i++) begin
      if (nibble_invalid(BCD_i[4*i +: 4])) bcd_invalid = 1'b1;
    end
  end

  assign bcd_shifted = bcd_reg >> 1;

  for (genvar g = 0; g < INPUT_DIGITS; g++) begin : g_adjust
    dabble_sub3 u_adjust (
      .digit    (bcd_shifted[4*g +: 4]),
      .adjusted (bcd_next[4*g +: 4])
    );
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      Busy_o    <= 1'b0;
      Done_o    <= 1'b0;
      Binary_o  <= '0;
      Error_o   <= 1'b0;
      bcd_reg   <= '0;
      bin_reg   <= '0;
      count     <= '0;
      digit_err <= 1'b0;
    end else begin
      Done_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // Publishing the finished result and accepting a new start share this cycle.
          if (state == DONE) begin
            Done_o   <= 1'b1;
            Binary_o <= bin_reg;
            Error_o  <= digit_err | (|bcd_reg);
          end
          if (Start_i) begin
            bin_reg <= '0;
            if (bcd_invalid) begin
              state     <= DONE;
              bcd_reg   <= '0;
              digit_err <= 1'b1;
            end else begin
              state     <= SHIFT;
              Busy_o    <= 1'b1;
              bcd_reg   <= BCD_i;
              count     <= '0;
              digit_err <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_next;
          bin_reg <= {bcd_reg[0], bin_reg[OUTPUT_BITS-1:1]};
          count   <= count + 1'b1;
          if (count == LAST_ITER) begin
            state  <= DONE;
            Busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reverse_dabble.sv
// Bench for reverse_dabble: constant vector table, hand-written multi-cycle
// sequences and randomised conversions against a decimal-arithmetic model.
module tb_reverse_dabble;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start_i;
  logic [19:0] BCD_i;
  logic        Busy_o;
  logic        Done_o;
  logic [15:0] Binary_o;
  logic        Error_o;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  reverse_dabble #(.INPUT_DIGITS(5), .OUTPUT_BITS(16)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start_i  (Start_i),
    .BCD_i    (BCD_i),
    .Busy_o   (Busy_o),
    .Done_o   (Done_o),
    .Binary_o (Binary_o),
    .Error_o  (Error_o)
  );

  typedef struct {
    logic [19:0] bcd;
    logic [15:0] bin;
    logic        err;
    int          lat;
    int          busy;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Decimal value of the digits; any digit above 9 is a rejected input.
  task automatic model(input logic [19:0] bcd, output logic [15:0] bin, output logic err,
                       output int lat);
    int unsigned value = 0;
    bit bad = 0;
    for (int i = 4; i >= 0; i--) begin
      int unsigned d = bcd[4*i +: 4];
      if (d > 9) bad = 1;
      value = value * 10 + d;
    end
    if (bad) begin
      bin = '0; err = 1'b1; lat = 1;
    end else begin
      bin = 16'(value % 65536); err = (value >= 65536); lat = 17;
    end
  endtask

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic run_conv(input logic [19:0] bcd, output logic [15:0] bin, output logic err,
                          output int lat, output int busy);
    @(negedge Clock);
    Start_i = 1'b1;
    BCD_i   = bcd;
    @(posedge Clock);
    #1;
    Start_i = 1'b0;
    BCD_i   = 20'($urandom);
    lat     = -1;
    busy    = Busy_o ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clock);
      #1;
      if (Done_o) begin
        lat = k;
        break;
      end
      if (Busy_o) busy++;
    end
    bin = Binary_o;
    err = Error_o;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clock);
      #1;
      if (Done_o) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    vec_t        vecs[$];
    logic [15:0] bin, ebin;
    logic        err, eerr;
    int          lat, elat, busy, pulses;
    logic [19:0] rbcd;

    Reset   = 1'b1;
    Start_i = 1'b0;
    BCD_i   = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset_busy", Busy_o, 0);
    check("reset_done", Done_o, 0);
    check("reset_bin",  Binary_o, 0);
    check("reset_err",  Error_o, 0);
    @(negedge Clock);
    Reset = 1'b0;

    vecs = '{
      '{20'h12345, 16'h3039, 1'b0, 17, 16},
      '{20'h65535, 16'hFFFF, 1'b0, 17, 16},
      '{20'h65536, 16'h0000, 1'b1, 17, 16},
      '{20'h99999, 16'h869F, 1'b1, 17, 16},
      '{20'h1A345, 16'h0000, 1'b1,  1,  0},
      '{20'h00000, 16'h0000, 1'b0, 17, 16},
      '{20'h00009, 16'h0009, 1'b0, 17, 16},
      '{20'h00010, 16'h000A, 1'b0, 17, 16},
      '{20'hF0000, 16'h0000, 1'b1,  1,  0},
      '{20'h00099, 16'h0063, 1'b0, 17, 16}
    };
    foreach (vecs[i]) begin
      run_conv(vecs[i].bcd, bin, err, lat, busy);
      check($sformatf("vec%0d_bin", i),  bin,  vecs[i].bin);
      check($sformatf("vec%0d_err", i),  err,  vecs[i].err);
      check($sformatf("vec%0d_lat", i),  lat,  vecs[i].lat);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
    end

    // Start held high: back-to-back conversions, input changes mid-flight ignored.
    @(negedge Clock);
    Start_i = 1'b1;
    BCD_i   = 20'h00000;
    @(posedge Clock);
    #1;
    BCD_i = 20'h00007;
    wait_done(lat);
    check("b2b0_lat", lat, 17);
    check("b2b0_bin", Binary_o, 16'h0000);
    BCD_i = 20'h00099;
    wait_done(lat);
    check("b2b1_lat", lat, 17);
    check("b2b1_bin", Binary_o, 16'h0007);
    Start_i = 1'b0;
    BCD_i   = 20'h54321;
    wait_done(lat);
    check("b2b2_lat", lat, 17);
    check("b2b2_bin", Binary_o, 16'h0063);
    @(posedge Clock);
    #1;
    check("b2b_idle_busy", Busy_o, 0);

    // Reset part-way through a conversion aborts it silently.
    run_conv(20'h99999, bin, err, lat, busy);
    check("pre_reset_err", err, 1);
    @(negedge Clock);
    Start_i = 1'b1;
    BCD_i   = 20'h12345;
    @(posedge Clock);
    #1;
    Start_i = 1'b0;
    repeat (8) @(posedge Clock);
    #1;
    check("mid_busy", Busy_o, 1);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    check("abort_busy", Busy_o, 0);
    check("abort_done", Done_o, 0);
    check("abort_bin",  Binary_o, 0);
    check("abort_err",  Error_o, 0);
    pulses = 0;
    repeat (25) begin
      @(posedge Clock);
      #1;
      if (Done_o) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_conv(20'h12345, bin, err, lat, busy);
    check("after_abort_bin", bin, 16'h3039);
    check("after_abort_lat", lat, 17);

    // Random in-range decimal values with random idle gaps.
    for (int n = 0; n < 250; n++) begin
      rbcd = to_bcd($urandom_range(0, 65535));
      model(rbcd, ebin, eerr, elat);
      repeat ($urandom_range(0, 3)) @(posedge Clock);
      run_conv(rbcd, bin, err, lat, busy);
      check($sformatf("rnd_bin_%05h", rbcd), bin, ebin);
      check($sformatf("rnd_err_%05h", rbcd), err, eerr);
      check($sformatf("rnd_lat_%05h", rbcd), lat, elat);
    end

    // Random raw 20-bit patterns: over-range values and invalid digits.
    for (int n = 0; n < 150; n++) begin
      rbcd = (n % 2 == 0) ? 20'($urandom) : to_bcd($urandom_range(65536, 99999));
      model(rbcd, ebin, eerr, elat);
      repeat ($urandom_range(0, 3)) @(posedge Clock);
      run_conv(rbcd, bin, err, lat, busy);
      check($sformatf("raw_bin_%05h", rbcd), bin, ebin);
      check($sformatf("raw_err_%05h", rbcd), err, eerr);
      check($sformatf("raw_lat_%05h", rbcd), lat, elat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reverse_dabble.md
# reverse_dabble

Sequential BCD-to-binary converter (reverse double dabble): it takes a packed BCD number and returns its binary value, one shift-and-correct step per clock. It is the inverse companion of the combinational binary-to-BCD converter. It sits behind keypad and UART decimal-entry paths, where numbers typed as digits must become binary operands. Invalid digits and results too wide for the output are flagged, not silently wrapped.

## Interface
- INPUT_DIGITS, 5, number of BCD digits accepted
- INPUT_BITS, INPUT_DIGITS*4, BCD input width (derived, not overridden)
- OUTPUT_BITS, 16, binary result width and number of shift iterations
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- Start_i  in  1  request conversion; sampled only when Busy_o is low
- BCD_i  in  INPUT_BITS  packed BCD, digit 0 in [3:0]; sampled on the accepting edge only
- Busy_o  out  1  high while iterating
- Done_o  out  1  one-cycle completion pulse
- Binary_o  out  OUTPUT_BITS  result, held until next completion
- Error_o  out  1  qualifies the last result; held with Binary_o

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE / DONE with Start_i=1:
  - If any nibble of BCD_i is >9: go to DONE. Next completion has Error_o=1 and Binary_o=0.
  - Otherwise load bcd_reg=BCD_i, bin_reg=0, iteration counter=0, and go to SHIFT.
- SHIFT, each cycle:
  - Right-shift {bcd_reg, bin_reg} by one. The LSB of bcd_reg enters the MSB of bin_reg; 0 enters the MSB of bcd_reg.
  - Then, in the same cycle, subtract 3 from every bcd_reg nibble whose shifted value is >=8.
  - Increment the counter. After OUTPUT_BITS iterations, go to DONE.
- DONE (one cycle):
  - Done_o=1. Binary_o=bin_reg.
  - Error_o=1 if the residual bcd_reg is nonzero (value >= 2^OUTPUT_BITS). Binary_o then holds the value mod 2^OUTPUT_BITS.
  - Next state is IDLE, or SHIFT/DONE if Start_i is accepted in this same cycle.
- Start_i while Busy_o=1 is ignored; there is no queueing.
- Arithmetic: corrections are per-nibble 4-bit operations with no carry between nibbles. Counter width is $clog2(OUTPUT_BITS+1).
- Reset: state IDLE, Busy_o=0, Done_o=0, Binary_o=0, Error_o=0, internal registers 0. Reset during SHIFT aborts the conversion with no Done_o pulse.

## Timing
- All outputs are registered.
- Valid input, Start_i accepted on edge N:
  - Busy_o is high from edge N to edge N+OUTPUT_BITS.
  - Done_o, Binary_o and Error_o update at edge N+OUTPUT_BITS+1 (17 cycles at the default width).
- Invalid digit, Start_i accepted on edge N: Done_o at edge N+1, and Busy_o never rises.
- Throughput: a new Start_i may be accepted in the DONE cycle, so back-to-back conversions take OUTPUT_BITS+1 cycles each.
- Binary_o and Error_o change only on a Done_o edge or on reset.

## Structure
- Shared package `reverse_dabble_pkg` holds:
  - state encoding localparams (IDLE, SHIFT, DONE);
  - the constant 4'd8 threshold and 4'd3 correction.
- Sub-module `dabble_sub3`: combinational single-nibble adjust (in >=8 ? in-3 : in). It is instantiated INPUT_DIGITS times through a generate loop.
- Remaining logic (FSM, counter, shift registers, digit-valid check, output registers) lives in the top module.

## Test plan
- BCD_i=20'h12345, Start_i pulse -> Done_o 17 cycles later, Binary_o=16'h3039, Error_o=0, Busy_o high for exactly 16 cycles.
- BCD_i=20'h65535 -> Binary_o=16'hFFFF, Error_o=0. BCD_i=20'h65536 -> Binary_o=16'h0000, Error_o=1. BCD_i=20'h99999 -> Binary_o=16'h869F, Error_o=1.
- BCD_i=20'h1A345 -> Done_o one cycle after Start_i, Binary_o=0, Error_o=1, Busy_o never high.
- Start_i held high continuously with BCD_i=20'h00000, then 20'h00007 -> Done_o pulses every 17 cycles, Binary_o=0 then 7. Changing BCD_i mid-conversion does not affect the result.
- Reset asserted at iteration 8 of a 20'h12345 conversion -> next cycle all outputs 0, no Done_o pulse. A fresh Start_i then converts correctly.
- Exhaustive sweep 0..65535 (BCD-encoded), randomised idle gaps -> Binary_o equals the decimal value, Error_o=0 for every value.
